// File: rtl/serial_adder_ctrl_if.sv
// Requester <-> bit-serial adder bus: operands and start in, busy/done/result out.
// Latency: n/a (signal bundle only).
// Backpressure: none; start is only honoured while the adder is idle (busy=0, done=0).
// Signals: start, a, b, carry_in (requester -> adder); busy, done, sum, carry_out (adder -> requester).
interface serial_adder_ctrl_if #(
  parameter int NUM_BITS = 8
);
  logic                start;
  logic [NUM_BITS-1:0] a;
  logic [NUM_BITS-1:0] b;
  logic                carry_in;
  logic                busy;
  logic                done;
  logic [NUM_BITS-1:0] sum;
  logic                carry_out;

  modport master (
    output start, a, b, carry_in,
    input  busy, done, sum, carry_out
  );

  modport slave (
    input  start, a, b, carry_in,
    output busy, done, sum, carry_out
  );
endinterface

// File: rtl/serial_adder_ctrl.sv
// One-bit full-adder cell shared by the serial sequencer below.
// Latency: combinational.
// Backpressure: none.
// Ports: i_a, i_b, i_cin in; o_sum, o_cout out.
module adder_1bit (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));
endmodule

// Bit-serial NUM_BITS adder: one adder_1bit cell, LSB first, internal carry register.
// Latency: start accepted at edge k -> sum/carry_out load and done pulses at edge k+NUM_BITS.
// Backpressure: start ignored while busy or done; no queueing, requester must wait for done.
// Ports: clk, rst (async, active-high); bus = serial_adder_ctrl_if slave
//   (start/a/b/carry_in in, busy/done/sum/carry_out out).
module serial_adder_ctrl #(
  parameter int NUM_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_adder_ctrl_if.slave   bus
);
  localparam int CNT_W = $clog2(NUM_BITS) + 1;
  localparam int SUM_W = NUM_BITS + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_BITS-1:0] r_a_sr;
  logic [NUM_BITS-1:0] r_b_sr;
  logic [NUM_BITS-1:0] r_part;
  logic                r_carry;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_BITS-1:0] r_sum;
  logic                r_cout;
  logic                r_busy;
  logic                r_done;

  logic                w_cell_sum;
  logic                w_cell_cout;
  logic [NUM_BITS-1:0] w_msb;
  logic [NUM_BITS-1:0] w_part_next;

  adder_1bit u_cell (
    .i_a    (r_a_sr[0]),
    .i_b    (r_b_sr[0]),
    .i_cin  (r_carry),
    .o_sum  (w_cell_sum),
    .o_cout (w_cell_cout)
  );

  // New sum bit enters at the MSB; after NUM_BITS shifts bit 0 has reached the LSB.
  // Built with a masked OR so the NUM_BITS=1 case needs no zero-width slice.
  always_comb begin
    w_msb               = '0;
    w_msb[NUM_BITS-1]   = w_cell_sum;
    w_part_next         = (r_part >> 1) | w_msb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a_sr  <= '0;
      r_b_sr  <= '0;
      r_part  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_a_sr  <= bus.a;
            r_b_sr  <= bus.b;
            r_carry <= bus.carry_in;
            r_part  <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_ADD;
          end
        end
        S_ADD: begin
          r_a_sr  <= r_a_sr >> 1;
          r_b_sr  <= r_b_sr >> 1;
          r_part  <= w_part_next;
          r_carry <= w_cell_cout;
          if (r_cnt == LAST_CNT) begin
            // Result registers change only here, so they stay stable through ADD.
            r_sum   <= w_part_next;
            r_cout  <= w_cell_cout;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.sum       = r_sum;
  assign bus.carry_out = r_cout;

  // Golden reference captured alongside the operands; it feeds only the
  // result check below and has no functional fan-out.
  logic [SUM_W-1:0] r_gold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gold <= '0;
    end else if (r_state == S_IDLE && bus.start) begin
      r_gold <= SUM_W'(bus.a) + SUM_W'(bus.b) + SUM_W'(bus.carry_in);
    end
  end

  always @(posedge clk) begin
    if (!rst && r_state == S_IDLE && bus.start) begin
      assert (!$isunknown({bus.a, bus.b, bus.carry_in}))
        else $error("serial_adder_ctrl: X/Z operand at accepted start");
    end
    if (!rst && r_done) begin
      assert ({r_cout, r_sum} == r_gold)
        else $error("serial_adder_ctrl: result %0h differs from golden %0h", {r_cout, r_sum}, r_gold);
    end
  end
endmodule
